// File: rtl/slurm32_cpu_memory_if.sv
// Data-bus handshake between the SLURM32 memory stage (master) and the memory system (slave).
interface slurm32_cpu_memory_if #(
   parameter int unsigned ADDR_BITS = 32
);
   logic [ADDR_BITS-1:0] bus_addr;
   logic [31:0]          bus_wr_data;
   logic [3:0]           bus_wr_mask;
   logic                 bus_wr;
   logic                 bus_valid;
   logic                 bus_ready;
   logic [31:0]          bus_rd_data;

   modport master (
      output bus_addr, bus_wr_data, bus_wr_mask, bus_wr, bus_valid,
      input  bus_ready, bus_rd_data
   );

   modport slave (
      input  bus_addr, bus_wr_data, bus_wr_mask, bus_wr, bus_valid,
      output bus_ready, bus_rd_data
   );
endinterface

// File: rtl/slurm32_cpu_memory.sv
// SLURM32 pipeline stage 3: drives the data-bus handshake for loads/stores,
// aligns load data and registers the stage-4 slot for writeback.
module slurm32_cpu_memory #(
   parameter int unsigned ADDR_BITS = 32
) (
   input  logic        CLK,
   input  logic        RSTb,
   input  logic [31:0] instruction,
   input  logic [31:0] pc_stage3,
   input  logic        nop_stage3,
   input  logic        mem_load,
   input  logic        mem_store,
   input  logic [1:0]  mem_size,
   input  logic        mem_signed,
   input  logic [31:0] aluOut,
   input  logic [31:0] store_data,
   slurm32_cpu_memory_if.master bus,
   output logic        stall,
   output logic        misalign_exc,
   output logic [31:0] instruction_stage4,
   output logic [31:0] pc_stage4,
   output logic        nop_stage4,
   output logic [31:0] memory_in,
   output logic [3:0]  memory_mask_delayed
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned MASK_W = 4;
   localparam int unsigned SIZE_W = 2;
   localparam int unsigned LANE_W = 2;

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   typedef struct packed {
      logic [DATA_W-1:0] addr;
      logic              wr;
      logic [MASK_W-1:0] mask;
      logic [DATA_W-1:0] wr_data;
      logic [SIZE_W-1:0] size;
      logic              sgn;
      logic [LANE_W-1:0] lane;
      logic              load;
   } req_t;

   state_t            state_q, state_d;
   req_t              in_req, req_q, req;
   logic              mem_op, in_misalign, misalign_op, valid, done_load;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [DATA_W-1:0] ld_data;

   // Decode the stage-3 request: lanes, replicated store data, alignment.
   always_comb begin : decode
      in_req         = '0;
      in_misalign    = 1'b0;
      in_req.addr    = {aluOut[DATA_W-1:2], 2'b00};
      in_req.wr      = mem_store;
      in_req.load    = mem_load & ~mem_store;
      in_req.size    = mem_size;
      in_req.sgn     = mem_signed;
      in_req.lane    = aluOut[1:0];
      case (mem_size)
         2'd0: begin
            in_req.mask    = MASK_W'(1) << aluOut[1:0];
            in_req.wr_data = {4{store_data[7:0]}};
         end
         2'd1: begin
            in_req.mask    = aluOut[1] ? 4'b1100 : 4'b0011;
            in_req.wr_data = {2{store_data[15:0]}};
            in_misalign    = aluOut[0];
         end
         default: begin
            in_req.mask    = 4'b1111;
            in_req.wr_data = store_data;
            in_misalign    = |aluOut[1:0];
         end
      endcase
      mem_op = (mem_load | mem_store) & ~nop_stage3;
   end

   // Next state and handshake; bus_valid and stall are gated by reset so they drop at once.
   always_comb begin : fsm_next
      state_d     = state_q;
      req         = in_req;
      valid       = 1'b0;
      misalign_op = 1'b0;
      case (state_q)
         IDLE: begin
            valid       = RSTb & mem_op & ~in_misalign;
            misalign_op = mem_op & in_misalign;
            if (valid && !bus.bus_ready) state_d = WAIT;
         end
         WAIT: begin
            req   = req_q;
            valid = RSTb;
            if (bus.bus_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      stall     = valid & ~bus.bus_ready;
      done_load = valid & bus.bus_ready & req.load;
   end

   // Pick the addressed lane(s) of the read word and extend.
   always_comb begin : load_align
      ld_byte = bus.bus_rd_data[7:0];
      ld_half = req.lane[1] ? bus.bus_rd_data[31:16] : bus.bus_rd_data[15:0];
      ld_data = bus.bus_rd_data;
      case (req.lane)
         2'd1:    ld_byte = bus.bus_rd_data[15:8];
         2'd2:    ld_byte = bus.bus_rd_data[23:16];
         2'd3:    ld_byte = bus.bus_rd_data[31:24];
         default: ld_byte = bus.bus_rd_data[7:0];
      endcase
      case (req.size)
         2'd0:    ld_data = {{24{req.sgn & ld_byte[7]}}, ld_byte};
         2'd1:    ld_data = {{16{req.sgn & ld_half[15]}}, ld_half};
         default: ld_data = bus.bus_rd_data;
      endcase
   end

   assign bus.bus_addr    = ADDR_BITS'(req.addr);
   assign bus.bus_wr_data = req.wr_data;
   assign bus.bus_wr_mask = req.mask;
   assign bus.bus_wr      = req.wr;
   assign bus.bus_valid   = valid;

   // State register; the request is snapshotted every IDLE cycle so WAIT replays it.
   always_ff @(posedge CLK or negedge RSTb) begin : fsm_state
      if (!RSTb) begin
         state_q <= IDLE;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE) req_q <= in_req;
      end
   end

   // Stage-4 slot: bubble while stalled, otherwise advance.
   always_ff @(posedge CLK or negedge RSTb) begin : stage4
      if (!RSTb) begin
         instruction_stage4  <= '0;
         pc_stage4           <= '0;
         nop_stage4          <= 1'b1;
         memory_in           <= '0;
         memory_mask_delayed <= '0;
         misalign_exc        <= 1'b0;
      end else if (stall) begin
         nop_stage4          <= 1'b1;
         memory_mask_delayed <= '0;
         misalign_exc        <= 1'b0;
      end else begin
         instruction_stage4 <= instruction;
         pc_stage4          <= pc_stage3;
         nop_stage4         <= nop_stage3 | misalign_op;
         misalign_exc       <= misalign_op;
         if (done_load) begin
            memory_in           <= ld_data;
            memory_mask_delayed <= req.mask;
         end else begin
            memory_mask_delayed <= '0;
         end
      end
   end

endmodule

// File: tb/tb_slurm32_cpu_memory.sv
// Scoreboard bench for slurm32_cpu_memory: directed ops push expectations, a negedge monitor checks them.
module tb_slurm32_cpu_memory;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instruction = '0;
   logic [31:0] pc_stage3 = '0;
   logic        nop_stage3 = 1'b1;
   logic        mem_load = 1'b0;
   logic        mem_store = 1'b0;
   logic [1:0]  mem_size = '0;
   logic        mem_signed = 1'b0;
   logic [31:0] alu_out = '0;
   logic [31:0] store_data = '0;
   logic        stall, misalign_exc, nop_stage4;
   logic [31:0] instruction_stage4, pc_stage4, memory_in;
   logic [3:0]  memory_mask_delayed;

   slurm32_cpu_memory_if #(.ADDR_BITS(32)) bus ();

   slurm32_cpu_memory #(.ADDR_BITS(32)) dut (
      .CLK(clk), .RSTb(rst_n),
      .instruction(instruction), .pc_stage3(pc_stage3), .nop_stage3(nop_stage3),
      .mem_load(mem_load), .mem_store(mem_store), .mem_size(mem_size),
      .mem_signed(mem_signed), .aluOut(alu_out), .store_data(store_data),
      .bus(bus),
      .stall(stall), .misalign_exc(misalign_exc),
      .instruction_stage4(instruction_stage4), .pc_stage4(pc_stage4),
      .nop_stage4(nop_stage4), .memory_in(memory_in),
      .memory_mask_delayed(memory_mask_delayed)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] mem;
      logic        nop;
      logic [3:0]  mask;
      logic        exc;
   } retire_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        wr;
      logic [3:0]  mask;
   } busreq_t;

   retire_t retire_q[$];
   busreq_t bus_q[$];
   int      stall_q[$];

   int          n_cmp = 0;
   int          n_err = 0;
   int          idx = 0;
   logic [31:0] last_mem = '0;
   logic        done = 1'b0;

   // One directed op: drive stage 3, push expectations, wait out the bus waits.
   task automatic run(input logic nop, input logic ld, input logic st, input logic [1:0] size,
                      input logic sgn, input logic [31:0] addr, input logic [31:0] sdata,
                      input logic [31:0] rdata, input int waits,
                      input logic [31:0] e_baddr, input logic [31:0] e_bdata, input logic [3:0] e_bmask,
                      input logic [31:0] e_mem, input logic [3:0] e_lmask, input logic e_exc);
      busreq_t b;
      retire_t r;
      idx         = idx + 1;
      instruction = 32'h1000_0000 + 32'(idx);
      pc_stage3   = 32'h0000_4000 + 32'(idx * 4);
      nop_stage3  = nop;
      mem_load    = ld;
      mem_store   = st;
      mem_size    = size;
      mem_signed  = sgn;
      alu_out     = addr;
      store_data  = sdata;
      bus.bus_rd_data = rdata;
      bus.bus_ready   = (waits == 0);
      if ((ld || st) && !nop && !e_exc) begin
         b.addr = e_baddr; b.data = e_bdata; b.wr = st; b.mask = e_bmask;
         bus_q.push_back(b);
      end
      if (waits > 0) stall_q.push_back(waits);
      if (e_lmask != 4'h0) last_mem = e_mem;
      if (!nop) begin
         r.instr = instruction; r.pc = pc_stage3; r.mem = last_mem;
         r.nop = e_exc; r.mask = e_lmask; r.exc = e_exc;
         retire_q.push_back(r);
      end
      if (waits > 0) begin
         repeat (waits) @(posedge clk);
         #1 bus.bus_ready = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: all comparisons happen here, on the falling edge.
   initial begin : monitor
      int      stall_run;
      logic    prev_stall;
      busreq_t prev_bus;
      busreq_t got;
      retire_t e;
      logic    prev_valid;
      stall_run  = 0;
      prev_stall = 1'b0;
      prev_valid = 1'b0;
      prev_bus   = '0;
      forever begin
         @(negedge clk);
         got.addr = bus.bus_addr; got.data = bus.bus_wr_data;
         got.wr = bus.bus_wr; got.mask = bus.bus_wr_mask;
         if (!rst_n) begin
            chk("rst_bus_valid", 32'(bus.bus_valid), 32'd0);
            chk("rst_stall", 32'(stall), 32'd0);
            chk("rst_nop_stage4", 32'(nop_stage4), 32'd1);
            chk("rst_mask", 32'(memory_mask_delayed), 32'd0);
            chk("rst_exc", 32'(misalign_exc), 32'd0);
            chk("rst_memory_in", memory_in, 32'd0);
            chk("rst_instr4", instruction_stage4, 32'd0);
            chk("rst_pc4", pc_stage4, 32'd0);
            stall_run  = 0;
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("bubble_nop", 32'(nop_stage4), 32'd1);
               chk("bubble_mask", 32'(memory_mask_delayed), 32'd0);
               chk("hold_valid", 32'(bus.bus_valid), 32'(prev_valid));
               chk("hold_addr", got.addr, prev_bus.addr);
               chk("hold_data", got.data, prev_bus.data);
               chk("hold_wr_mask", 32'({got.wr, got.mask}), 32'({prev_bus.wr, prev_bus.mask}));
            end
            if (bus.bus_valid && bus.bus_ready) begin
               if (bus_q.size() == 0) begin
                  n_cmp = n_cmp + 1; n_err = n_err + 1;
                  $display("FAIL bus_unexpected: got addr %h, expected no request", got.addr);
               end else begin
                  b_check(bus_q.pop_front(), got);
               end
            end
            if (!nop_stage4 || misalign_exc) begin
               if (retire_q.size() == 0) begin
                  n_cmp = n_cmp + 1; n_err = n_err + 1;
                  $display("FAIL retire_unexpected: got instr %h, expected none", instruction_stage4);
               end else begin
                  e = retire_q.pop_front();
                  chk("ret_instr", instruction_stage4, e.instr);
                  chk("ret_pc", pc_stage4, e.pc);
                  chk("ret_nop", 32'(nop_stage4), 32'(e.nop));
                  chk("ret_memory_in", memory_in, e.mem);
                  chk("ret_mask", 32'(memory_mask_delayed), 32'(e.mask));
                  chk("ret_exc", 32'(misalign_exc), 32'(e.exc));
               end
            end
            if (stall) begin
               stall_run = stall_run + 1;
            end else if (stall_run > 0) begin
               if (stall_q.size() == 0) begin
                  n_cmp = n_cmp + 1; n_err = n_err + 1;
                  $display("FAIL stall_unexpected: got %0d stall cycles, expected 0", stall_run);
               end else begin
                  chk("stall_cycles", 32'(stall_run), 32'(stall_q.pop_front()));
               end
               stall_run = 0;
            end
            prev_stall = stall;
            prev_valid = bus.bus_valid;
            prev_bus   = got;
         end
         if (done) begin
            chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
            chk("retire_q_drained", 32'(retire_q.size()), 32'd0);
            chk("stall_q_drained", 32'(stall_q.size()), 32'd0);
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
            $finish;
         end
      end
   end

   task automatic b_check(input busreq_t e, input busreq_t g);
      chk("bus_addr", g.addr, e.addr);
      chk("bus_wr_data", g.data, e.data);
      chk("bus_wr", 32'(g.wr), 32'(e.wr));
      chk("bus_wr_mask", 32'(g.mask), 32'(e.mask));
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   // Directed stimulus.
   initial begin : stimulus
      bus.bus_ready   = 1'b0;
      bus.bus_rd_data = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      //   nop ld st sz sg addr          sdata         rdata         w  e_baddr       e_bdata       bmask  e_mem         lmask  exc
      run(0, 1, 0, 2, 0, 32'h0000_0100, 32'h0,        32'hdeadbeef, 0, 32'h0000_0100, 32'h0,        4'hf, 32'hdeadbeef, 4'hf, 0);
      run(0, 1, 0, 0, 1, 32'h0000_0103, 32'h0,        32'h80112233, 0, 32'h0000_0100, 32'h0,        4'h8, 32'hffffff80, 4'h8, 0);
      run(0, 1, 0, 0, 0, 32'h0000_0103, 32'h0,        32'h80112233, 0, 32'h0000_0100, 32'h0,        4'h8, 32'h00000080, 4'h8, 0);
      run(0, 0, 1, 1, 0, 32'h0000_0202, 32'h1234abcd, 32'h0,        0, 32'h0000_0200, 32'habcdabcd, 4'hc, 32'h0,        4'h0, 0);
      run(0, 1, 0, 2, 0, 32'h0000_0300, 32'h0,        32'hcafef00d, 3, 32'h0000_0300, 32'h0,        4'hf, 32'hcafef00d, 4'hf, 0);
      run(0, 1, 0, 2, 0, 32'h0000_0102, 32'h0,        32'h0,        0, 32'h0,         32'h0,        4'h0, 32'h0,        4'h0, 1);
      run(0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0,        0, 32'h0,         32'h0,        4'h0, 32'h0,        4'h0, 0);
      run(0, 1, 0, 1, 1, 32'h0000_0106, 32'h0,        32'h9abc1234, 0, 32'h0000_0104, 32'h0,        4'hc, 32'hffff9abc, 4'hc, 0);
      run(0, 1, 0, 1, 0, 32'h0000_0500, 32'h0,        32'h1234fedc, 1, 32'h0000_0500, 32'h0,        4'h3, 32'h0000fedc, 4'h3, 0);
      run(0, 0, 1, 0, 0, 32'h0000_0401, 32'h000000a5, 32'h0,        0, 32'h0000_0400, 32'ha5a5a5a5, 4'h2, 32'h0,        4'h0, 0);
      run(0, 0, 1, 1, 0, 32'h0000_0203, 32'h00000055, 32'h0,        0, 32'h0,         32'h0,        4'h0, 32'h0,        4'h0, 1);
      run(0, 1, 0, 3, 0, 32'h0000_0010, 32'h0,        32'h01020304, 0, 32'h0000_0010, 32'h0,        4'hf, 32'h01020304, 4'hf, 0);
      run(0, 1, 1, 0, 1, 32'h0000_0022, 32'h0000007e, 32'hffffffff, 0, 32'h0000_0020, 32'h7e7e7e7e, 4'h4, 32'h0,        4'h0, 0);
      run(1, 1, 0, 2, 0, 32'h0000_0102, 32'h0,        32'h0,        0, 32'h0,         32'h0,        4'h0, 32'h0,        4'h0, 0);
      run(0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0,        0, 32'h0,         32'h0,        4'h0, 32'h0,        4'h0, 0);
      run(0, 0, 1, 2, 0, 32'h0000_0700, 32'h11223344, 32'h0,        2, 32'h0000_0700, 32'h11223344, 4'hf, 32'h0,        4'h0, 0);
      run(0, 1, 0, 0, 1, 32'h0000_0801, 32'h0,        32'h00007f00, 0, 32'h0000_0800, 32'h0,        4'h2, 32'h0000007f, 4'h2, 0);

      // Park a load in WAIT, then reset underneath it.
      instruction = 32'h2000_0000; pc_stage3 = 32'h0000_6000;
      nop_stage3 = 1'b0; mem_load = 1'b1; mem_store = 1'b0; mem_size = 2'd2;
      alu_out = 32'h0000_0600; bus.bus_ready = 1'b0; bus.bus_rd_data = 32'h0badf00d;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      nop_stage3 = 1'b1; mem_load = 1'b0; bus.bus_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      last_mem = '0;
      @(posedge clk);
      #1;
      run(0, 0, 0, 0, 0, 32'h0,         32'h0,        32'h0,        0, 32'h0,         32'h0,        4'h0, 32'h0,        4'h0, 0);
      run(0, 1, 0, 2, 0, 32'h0000_0900, 32'h0,        32'h13579bdf, 0, 32'h0000_0900, 32'h0,        4'hf, 32'h13579bdf, 4'hf, 0);

      nop_stage3 = 1'b1; mem_load = 1'b0; mem_store = 1'b0; bus.bus_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 done = 1'b1;
   end

endmodule

// File: doc/slurm32_cpu_memory.md
Name: slurm32_cpu_memory

Overview:
- Pipeline stage 3 of the SLURM32 CPU, directly upstream of slurm32_cpu_writeback.
- Takes the decoded load/store request and the ALU-computed address from stage 3, and drives the data-bus handshake.
- Aligns and extends load data, then registers everything writeback needs for stage 4: instruction, pc, nop flag, load data, memory_mask_delayed.
- Stalls the upstream pipeline while a bus transaction is outstanding.

Parameters:
- ADDR_BITS, 32, width of the byte address presented on the bus.

Ports:
- CLK  in  1  system clock, rising edge.
- RSTb  in  1  asynchronous active-low reset.
- instruction  in  32  instruction in pipeline slot 3.
- pc_stage3  in  32  PC of the slot-3 instruction.
- nop_stage3  in  1  slot-3 instruction is NOP'd out.
- mem_load  in  1  slot-3 instruction is a load.
- mem_store  in  1  slot-3 instruction is a store.
- mem_size  in  2  access size: 0 = byte, 1 = half, 2 = word; 3 is reserved and treated as word.
- mem_signed  in  1  sign-extend a byte/half load.
- aluOut  in  32  effective byte address from the ALU.
- store_data  in  32  register data to store (low bits significant).
- bus_addr  out  ADDR_BITS  word-aligned address; bits [1:0] are always 0.
- bus_wr_data  out  32  store data with lanes replicated.
- bus_wr_mask  out  4  byte enables; bit n = byte lane n.
- bus_wr  out  1  1 = write, 0 = read.
- bus_valid  out  1  request valid.
- bus_ready  in  1  request accepted this cycle; read data valid this cycle.
- bus_rd_data  in  32  raw read word.
- stall  out  1  freeze stages 1–3.
- misalign_exc  out  1  one-cycle pulse: misaligned access was dropped.
- instruction_stage4  out  32  to writeback.
- pc_stage4  out  32  to writeback.
- nop_stage4  out  1  to writeback.
- memory_in  out  32  aligned and extended load data, to writeback.
- memory_mask_delayed  out  4  registered load mask, to writeback; 0 for non-loads.

Behaviour:
- Reset (async, RSTb = 0):
  - all registered outputs go to 0, except nop_stage4, which goes to 1;
  - FSM goes to IDLE;
  - bus_valid and stall deassert immediately, even mid-transaction; any pending bus response is ignored after reset.
- Memory op definition: mem_op = (mem_load | mem_store) & !nop_stage3. If both mem_load and mem_store are high, the op is a store.
- Misalignment:
  - a half access is misaligned if aluOut[0] = 1;
  - a word access is misaligned if aluOut[1:0] ≠ 0;
  - misaligned ops never assert bus_valid.
- Byte lanes (little-endian, lane L = aluOut[1:0]):
  - byte: mask = 1 << L;
  - half: mask = aluOut[1] ? 4'b1100 : 4'b0011;
  - word: mask = 4'b1111.
- Store data replication:
  - byte: store_data[7:0] ×4 lanes;
  - half: store_data[15:0] ×2 halves;
  - word: store_data unchanged.
- Load extraction: take the selected lane(s) of bus_rd_data, shift to bits [7:0] or [15:0], then zero-extend, or sign-extend when mem_signed = 1. Word loads pass through unchanged.
- FSM:
  - IDLE: bus_valid = aligned mem_op (combinational, same cycle). bus_addr, bus_wr, bus_wr_mask and bus_wr_data are driven from the stage-3 inputs. If bus_valid & bus_ready, the op completes this cycle and the state stays IDLE. If bus_valid & !bus_ready, go to WAIT.
  - WAIT: the request is held stable from registered copies and stage-3 inputs are ignored. Go back to IDLE on the cycle bus_ready = 1.
- Stall: stall = bus_valid & !bus_ready (combinational). Upstream holds stage 3 stable while stalled.
- Stage-4 register update (every rising edge):
  - Stalled cycle: a bubble is inserted. nop_stage4 = 1, memory_mask_delayed = 0; all other stage-4 registers hold.
  - Otherwise: instruction_stage4 = instruction and pc_stage4 = pc_stage3.
    - nop_stage4 = nop_stage3 | misaligned mem_op.
    - memory_mask_delayed = mask for a completed aligned load, else 0.
    - memory_in = extracted data for a completed aligned load, else it holds.
- Latency:
  - zero-wait bus: one cycle from stage 3 to stage 4;
  - each bus wait cycle adds one bubble.
- misalign_exc: registered; high for exactly the one cycle when nop_stage4 reflects the dropped op. It is not re-issued while stalled.
- Non-memory ops pass through in one cycle with bus_valid = 0.

Test Plan:
1. Word load, aluOut = 0x100, bus_rd_data = 0xdeadbeef, bus_ready = 1 → same cycle bus_valid = 1, bus_addr = 0x100, bus_wr = 0. Next edge: memory_in = 0xdeadbeef, memory_mask_delayed = 4'hf, nop_stage4 = 0, stall never asserted.
2. Signed byte load, aluOut = 0x103, bus_rd_data = 0x80112233 → memory_in = 0xffffff80, mask = 4'b1000. Same with mem_signed = 0 → memory_in = 0x00000080.
3. Half store, aluOut = 0x202, store_data = 0x1234abcd → bus_wr_data = 0xabcdabcd, bus_wr_mask = 4'b1100, bus_wr = 1. Next edge: memory_mask_delayed = 0.
4. Word load with bus_ready held low for 3 cycles → stall high for exactly 3 cycles, bus outputs stable throughout, 3 bubbles (nop_stage4 = 1), then load data appears once.
5. Word load at aluOut = 0x102 → bus_valid stays 0, stall = 0, next cycle misalign_exc = 1 and nop_stage4 = 1 for one cycle.
6. RSTb pulled low in WAIT → bus_valid and stall drop immediately, nop_stage4 = 1, memory_mask_delayed = 0. After release, FSM is IDLE and a bus_ready arriving then has no effect.
